// File: rtl/id_operand_stage_if.sv
// rtl/id_operand_stage_if.sv - ID/EX operand stage bus bundle; sel_err present only with ONEHOT_CHK_EN
interface id_operand_stage_if #(
  parameter int DW = 32,
  parameter int RW = 4,
  parameter int CW = 16
);
  logic          d_valid;
  logic [RW-1:0] d_ra;
  logic [CW-1:0] d_ctrl;
  logic [3:0]    fwd_sel_x;
  logic [3:0]    fwd_sel_y;
  logic [DW-1:0] rf_rb_data;
  logic [DW-1:0] rf_rc_data;
  logic [DW-1:0] e_res1;
  logic [DW-1:0] e_res2;
  logic          e_load1;
  logic          e_load2;
  logic [DW-1:0] m_res;
  logic          ex_ready;
  logic          flush;
  logic          stall_d;
  logic          x_valid;
  logic [DW-1:0] x_op;
  logic [DW-1:0] y_op;
  logic [RW-1:0] x_ra;
  logic [CW-1:0] x_ctrl;
  logic [7:0]    stall_cnt;
`ifdef ONEHOT_CHK_EN
  logic          sel_err;
`endif

  modport master (
`ifdef ONEHOT_CHK_EN
    input  sel_err,
`endif
    output d_valid, d_ra, d_ctrl, fwd_sel_x, fwd_sel_y, rf_rb_data, rf_rc_data,
    output e_res1, e_res2, e_load1, e_load2, m_res, ex_ready, flush,
    input  stall_d, x_valid, x_op, y_op, x_ra, x_ctrl, stall_cnt
  );

  modport slave (
`ifdef ONEHOT_CHK_EN
    output sel_err,
`endif
    input  d_valid, d_ra, d_ctrl, fwd_sel_x, fwd_sel_y, rf_rb_data, rf_rc_data,
    input  e_res1, e_res2, e_load1, e_load2, m_res, ex_ready, flush,
    output stall_d, x_valid, x_op, y_op, x_ra, x_ctrl, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - ID/EX operand mux, pipeline register, load-use interlock; ONEHOT_CHK_EN adds sel_err
module id_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_operand_stage_if.slave bus
);
  typedef enum logic [1:0] {RUN, INTLK, HOLD} state_t;

  state_t        state;
  logic          ld_use;
  logic [DW-1:0] x_mux;
  logic [DW-1:0] y_mux;
  logic          x_valid_q;
  logic [DW-1:0] x_op_q;
  logic [DW-1:0] y_op_q;
  logic [RW-1:0] x_ra_q;
  logic [CW-1:0] x_ctrl_q;
  logic [7:0]    stall_cnt_q;

  // Anything other than a single set bit falls back to the register file.
  function automatic logic [DW-1:0] op_mux(input logic [3:0] sel, input logic [DW-1:0] e1,
                                           input logic [DW-1:0] e2, input logic [DW-1:0] m,
                                           input logic [DW-1:0] rf);
    case (sel)
      4'b0001: return e1;
      4'b0010: return e2;
      4'b0100: return m;
      default: return rf;
    endcase
  endfunction

  assign x_mux = op_mux(bus.fwd_sel_x, bus.e_res1, bus.e_res2, bus.m_res, bus.rf_rb_data);
  assign y_mux = op_mux(bus.fwd_sel_y, bus.e_res1, bus.e_res2, bus.m_res, bus.rf_rc_data);

  assign ld_use = bus.d_valid &
                  (((bus.fwd_sel_x[0] | bus.fwd_sel_y[0]) & bus.e_load1) |
                   ((bus.fwd_sel_x[1] | bus.fwd_sel_y[1]) & bus.e_load2));

  assign bus.stall_d = ~rst & ~bus.flush &
                       (~bus.ex_ready | ((state != INTLK) & ld_use));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      x_valid_q   <= 1'b0;
      x_op_q      <= '0;
      y_op_q      <= '0;
      x_ra_q      <= '0;
      x_ctrl_q    <= '0;
      stall_cnt_q <= 8'd0;
    end else if (bus.flush) begin
      state     <= RUN;
      x_valid_q <= 1'b0;
    end else if (!bus.ex_ready) begin
      state <= HOLD;
    end else if ((state != INTLK) && ld_use) begin
      // One bubble per instruction; by the next cycle the load has reached MEM.
      state     <= INTLK;
      x_valid_q <= 1'b0;
      if (stall_cnt_q != 8'hFF) stall_cnt_q <= stall_cnt_q + 8'd1;
    end else begin
      state     <= RUN;
      x_valid_q <= bus.d_valid;
      x_op_q    <= x_mux;
      y_op_q    <= y_mux;
      x_ra_q    <= bus.d_ra;
      x_ctrl_q  <= bus.d_ctrl;
    end
  end

  assign bus.x_valid   = x_valid_q;
  assign bus.x_op      = x_op_q;
  assign bus.y_op      = y_op_q;
  assign bus.x_ra      = x_ra_q;
  assign bus.x_ctrl    = x_ctrl_q;
  assign bus.stall_cnt = stall_cnt_q;

`ifdef ONEHOT_CHK_EN
  logic sel_err_q;

  function automatic logic is_onehot(input logic [3:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (bus.d_valid && !(is_onehot(bus.fwd_sel_x) && is_onehot(bus.fwd_sel_y))) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`endif
endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - self-checking bench for id_operand_stage; build with ONEHOT_CHK_EN to cover sel_err
module tb_id_operand_stage;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_operand_stage_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

  id_operand_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: operand chosen by the single set select bit, register file otherwise.
  function automatic logic [DW-1:0] pick(input logic [3:0] sel, input logic [DW-1:0] rf);
    logic [DW-1:0] src [4];
    src[0] = bus.e_res1; src[1] = bus.e_res2; src[2] = bus.m_res; src[3] = rf;
    if ($countones(sel) != 1) return rf;
    for (int i = 0; i < 4; i++) if (sel[i]) return src[i];
    return rf;
  endfunction

  function automatic logic needs_loaded_value();
    logic uses_e1, uses_e2;
    uses_e1 = bus.fwd_sel_x[0] || bus.fwd_sel_y[0];
    uses_e2 = bus.fwd_sel_x[1] || bus.fwd_sel_y[1];
    return bus.d_valid && ((uses_e1 && bus.e_load1) || (uses_e2 && bus.e_load2));
  endfunction

  logic          m_live = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_x, m_y;
  logic [RW-1:0] m_ra;
  logic [CW-1:0] m_ctrl;
  int            m_cnt;
  logic          m_just_bubbled;
  logic          m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_valid = 1'b0; m_x = '0; m_y = '0; m_ra = '0; m_ctrl = '0;
      m_cnt = 0; m_just_bubbled = 1'b0; m_err = 1'b0;
    end else if (m_live) begin
      if (bus.d_valid && ($countones(bus.fwd_sel_x) != 1 || $countones(bus.fwd_sel_y) != 1))
        m_err = 1'b1;
      if (bus.flush) begin
        m_valid = 1'b0; m_just_bubbled = 1'b0;
      end else if (!bus.ex_ready) begin
        m_just_bubbled = 1'b0;
      end else if (needs_loaded_value() && !m_just_bubbled) begin
        m_valid = 1'b0; m_just_bubbled = 1'b1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else begin
        m_valid = bus.d_valid;
        m_x = pick(bus.fwd_sel_x, bus.rf_rb_data);
        m_y = pick(bus.fwd_sel_y, bus.rf_rc_data);
        m_ra = bus.d_ra; m_ctrl = bus.d_ctrl; m_just_bubbled = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("stall_d", bus.stall_d,
            !rst && !bus.flush && (!bus.ex_ready || (needs_loaded_value() && !m_just_bubbled)));
      check("x_valid", bus.x_valid, m_valid);
      check("x_op", bus.x_op, m_x);
      check("y_op", bus.y_op, m_y);
      check("x_ra", bus.x_ra, m_ra);
      check("x_ctrl", bus.x_ctrl, m_ctrl);
      check("stall_cnt", bus.stall_cnt, m_cnt[7:0]);
`ifdef ONEHOT_CHK_EN
      check("sel_err", bus.sel_err, m_err);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic plain(input logic [3:0] sx, input logic [3:0] sy);
    bus.fwd_sel_x = sx; bus.fwd_sel_y = sy; bus.e_load1 = 1'b0; bus.e_load2 = 1'b0;
  endtask

  logic [3:0] tbl_sel [6];
  logic [DW-1:0] tbl_exp [6];

  initial begin
    bus.d_valid = 1'b0; bus.d_ra = '0; bus.d_ctrl = '0;
    bus.fwd_sel_x = 4'b1000; bus.fwd_sel_y = 4'b1000;
    bus.rf_rb_data = '0; bus.rf_rc_data = '0; bus.e_res1 = '0; bus.e_res2 = '0;
    bus.e_load1 = 1'b0; bus.e_load2 = 1'b0; bus.m_res = '0;
    bus.ex_ready = 1'b0; bus.flush = 1'b0;

    rst = 1'b1;
    cyc(); cyc();
    check("rst stall_d", bus.stall_d, 1'b0);
    check("rst x_valid", bus.x_valid, 1'b0);
    check("rst stall_cnt", bus.stall_cnt, 8'd0);
    rst = 1'b0;

    // Test 1: E1 forward on X, regfile on Y.
    bus.ex_ready = 1'b1; bus.d_valid = 1'b1; bus.d_ra = 4'd3; bus.d_ctrl = 16'hBEEF;
    plain(4'b0001, 4'b1000); bus.e_res1 = 32'hA5; bus.rf_rc_data = 32'h3C;
    #1 check("t1 stall_d", bus.stall_d, 1'b0);
    cyc();
    check("t1 x_op", bus.x_op, 32'hA5);
    check("t1 y_op", bus.y_op, 32'h3C);
    check("t1 x_valid", bus.x_valid, 1'b1);

    // Test 2: load-use bubble, then MEM forward; then a back-to-back load on E2.
    bus.e_load1 = 1'b1;
    #1 check("t2 stall_d", bus.stall_d, 1'b1);
    cyc();
    check("t2 bubble", bus.x_valid, 1'b0);
    check("t2 cnt", bus.stall_cnt, 8'd1);
    bus.fwd_sel_x = 4'b0100; bus.m_res = 32'h77;
    #1 check("t2 intlk stall_d", bus.stall_d, 1'b0);
    cyc();
    check("t2 x_op", bus.x_op, 32'h77);
    check("t2 x_valid", bus.x_valid, 1'b1);
    plain(4'b1000, 4'b0010); bus.e_load2 = 1'b1; bus.e_res2 = 32'h55;
    cyc();
    check("t2 b2b cnt", bus.stall_cnt, 8'd2);
    bus.fwd_sel_y = 4'b0100; bus.m_res = 32'h66;
    cyc();
    check("t2 b2b y_op", bus.y_op, 32'h66);

    // Mux table: every select pattern including two non-one-hot fallbacks (no loads).
    bus.e_res1 = 32'h11; bus.e_res2 = 32'h22; bus.m_res = 32'h33; bus.rf_rb_data = 32'h44;
    tbl_sel[0] = 4'b0001; tbl_exp[0] = 32'h11;
    tbl_sel[1] = 4'b0010; tbl_exp[1] = 32'h22;
    tbl_sel[2] = 4'b0100; tbl_exp[2] = 32'h33;
    tbl_sel[3] = 4'b1000; tbl_exp[3] = 32'h44;
    tbl_sel[4] = 4'b0000; tbl_exp[4] = 32'h44;
    tbl_sel[5] = 4'b0110; tbl_exp[5] = 32'h44;
    for (int i = 0; i < 6; i++) begin
      plain(tbl_sel[i], 4'b1000);
      bus.d_valid = (i < 4);
      cyc();
      check("mux x_op", bus.x_op, tbl_exp[i]);
    end
    bus.d_valid = 1'b1;

    // Test 3: three cycles of EX back-pressure hold the register.
    plain(4'b1000, 4'b1000); bus.rf_rb_data = 32'h1111; bus.rf_rc_data = 32'h2222;
    bus.d_ra = 4'd5; bus.d_ctrl = 16'h1234;
    cyc();
    bus.ex_ready = 1'b0; bus.rf_rb_data = 32'h9999; bus.d_ra = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3 stall_d", bus.stall_d, 1'b1);
      cyc();
      check("t3 x_op held", bus.x_op, 32'h1111);
      check("t3 x_ra held", bus.x_ra, 4'd5);
    end
    bus.ex_ready = 1'b1;
    cyc();
    check("t3 x_op new", bus.x_op, 32'h9999);
    check("t3 x_ra new", bus.x_ra, 4'd6);

    // Test 4: flush beats back-pressure and load-use; flush during hold.
    bus.flush = 1'b1; bus.ex_ready = 1'b0; bus.fwd_sel_x = 4'b0001; bus.e_load1 = 1'b1;
    #1 check("t4 stall_d", bus.stall_d, 1'b0);
    cyc();
    check("t4 x_valid", bus.x_valid, 1'b0);
    check("t4 cnt", bus.stall_cnt, 8'd2);
    bus.flush = 1'b0; bus.ex_ready = 1'b1;
    #1 check("t4 run ldu", bus.stall_d, 1'b1);
    plain(4'b1000, 4'b1000);
    cyc();
    bus.ex_ready = 1'b0;
    cyc();
    bus.flush = 1'b1;
    cyc();
    check("t4 hold flush", bus.x_valid, 1'b0);
    bus.flush = 1'b0; bus.ex_ready = 1'b1;

    // Test 5: saturate the bubble counter, then reset mid-interlock.
    for (int i = 0; i < 256; i++) begin
      bus.fwd_sel_x = 4'b0001; bus.e_load1 = 1'b1;
      cyc();
      bus.fwd_sel_x = 4'b0100;
      cyc();
    end
    check("t5 sat", bus.stall_cnt, 8'd255);
    bus.fwd_sel_x = 4'b0001;
    cyc();
    check("t5 sat hold", bus.stall_cnt, 8'd255);
    rst = 1'b1;
    #1 check("t5 rst stall_d", bus.stall_d, 1'b0);
    cyc();
    check("t5 rst cnt", bus.stall_cnt, 8'd0);
    check("t5 rst x_op", bus.x_op, 32'd0);
    check("t5 rst x_valid", bus.x_valid, 1'b0);
    rst = 1'b0;
    plain(4'b1000, 4'b1000);
    cyc();

`ifdef ONEHOT_CHK_EN
    // Test 6: two select bits set falls back to RF and raises the sticky flag.
    plain(4'b0011, 4'b1000); bus.rf_rb_data = 32'hCAFE;
    cyc();
    check("t6 x_op", bus.x_op, 32'hCAFE);
    check("t6 sel_err", bus.sel_err, 1'b1);
    plain(4'b1000, 4'b1000);
    cyc(); cyc();
    check("t6 sticky", bus.sel_err, 1'b1);
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
